// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared defaults, op encoding, FSM states and an index helper.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 20;
  localparam int DEF_DW = 8;
  // Width of busy_ch and the round-robin pointer; covers up to 8 channels.
  localparam int IDX_W  = 3;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Advance a channel index by one, wrapping back to 0 at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// mem_port_arbiter_arb_pick: combinational picker. Chooses the lowest pending
// index at or above 'start', wrapping to the lowest pending index overall.
// Tying start to 0 gives fixed lowest-index-wins priority.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]   pend,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] idx
);

  logic             hi_hit;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan downwards so the last hit recorded is the lowest qualifying index.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and infers a latch.
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    any    = 1'b0;
    grant  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any    = 1'b1;
        lo_idx = IDX_W'(i);
        if (i >= int'(start)) begin
          hi_hit = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    idx = hi_hit ? hi_idx : lo_idx;
    for (int i = 0; i < NCH; i++) begin
      grant[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory back end among NCH requesters
// using begin_wr/begin_rd/finish handshakes. Each channel owns a one-deep
// request slot; a single IDLE/ISSUE/WAIT FSM serves one slot at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RR_MODE = 0
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_begin_wr,
  input  logic [NCH-1:0]    ch_begin_rd,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_data_wr,
  output logic [NCH-1:0]    ch_finish,
  output logic [NCH*DW-1:0] ch_data_rd,
  output logic [NCH-1:0]    ch_overrun,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic [2:0]        busy_ch
);

  state_e           state;
  state_e           state_nxt;
  logic             load;
  logic             done;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   clr_pend;
  logic [NCH-1:0]   pick_grant;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pick_start;
  logic [IDX_W-1:0] rr_ptr;
  op_e              slot_op   [NCH];
  logic [AW-1:0]    slot_addr [NCH];
  logic [DW-1:0]    slot_data [NCH];
  op_e              win_op;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    logic          start_req;
    logic          pend_q;
    logic          overrun_q;
    logic          finish_q;
    op_e           op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] rdata_q;

    assign start_req   = ch_begin_wr[i] | ch_begin_rd[i];
    assign clr_pend[i] = done && (busy_ch == IDX_W'(i));

    // Pending/overrun flags, completion pulse and returned read data.
    always_ff @(posedge mclk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!reset) begin
        pend_q    <= 1'b0;
        overrun_q <= 1'b0;
        finish_q  <= 1'b0;
        rdata_q   <= '0;
      end else begin
        finish_q <= clr_pend[i];
        if (clr_pend[i] && !mem_we) rdata_q <= mem_rdata;
        if (start_req && pend_q) overrun_q <= 1'b1;
        if (clr_pend[i])         pend_q <= 1'b0;
        else if (start_req)      pend_q <= 1'b1;
      end
    end

    // Request payload, captured only while the slot is free.
    always_ff @(posedge mclk) begin
      // NOTE: payload flops are deliberately not reset; pend_q qualifies them,
      // so their power-up contents are never forwarded.
      if (start_req && !pend_q) begin
        op_q   <= ch_begin_wr[i] ? OP_WR : OP_RD;
        addr_q <= ch_addr[i*AW +: AW];
        data_q <= ch_data_wr[i*DW +: DW];
      end
    end

    assign pend[i]                = pend_q;
    assign ch_overrun[i]          = overrun_q;
    assign ch_finish[i]           = finish_q;
    assign ch_data_rd[i*DW +: DW] = rdata_q;
    assign slot_op[i]             = op_q;
    assign slot_addr[i]           = addr_q;
    assign slot_data[i]           = data_q;
  end

  assign pick_start = (RR_MODE != 0) ? rr_ptr : '0;

  mem_port_arbiter_arb_pick #(.NCH(NCH)) u_pick (
    .pend  (pend),
    .start (pick_start),
    .any   (pick_any),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Route the granted slot's payload towards the back-end registers.
  always_comb begin
    win_op   = OP_RD;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_grant[i]) begin
        win_op   = slot_op[i];
        win_addr = slot_addr[i];
        win_data = slot_data[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the grant (load) and completion (done) strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // mem_req is only high in WAIT, so an ack outside WAIT has no effect.
  assign mem_req = (state == ST_WAIT);

  // Hold the winner's request on the back-end bus; track whom we serve.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy_ch   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      mem_we    <= (win_op == OP_WR);
      mem_addr  <= win_addr;
      mem_wdata <= win_data;
      busy_ch   <= pick_idx;
      rr_ptr    <= wrap_inc(pick_idx, NCH);
    end else if (done) begin
      busy_ch   <= '0;
    end
  end

endmodule
